// File: rtl/p88_loader.sv
// rtl/p88_loader.sv - P88 image loader: C8 data records to RAM writes, CA entry record to a boot-ROM far-JMP.
// Optional: define P88_ERR_EN to trap unknown record bytes into a sticky error state.
module p88_loader #(
  parameter int WR_PULSE = 1,
  parameter int ADDR_W   = 20
) (
  input  logic              clk_sys,
  input  logic              resetL,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              load_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wr,
  output logic              rom_wr,
  output logic              boot_valid,
  output logic              err
);

  typedef enum logic [4:0] {
    CMD, C8_SEGL, C8_SEGH, C8_OFFL, C8_OFFH, SKIP0, SKIP1, LENL, LENH,
    DATA, WPULSE, ADV, CA_SEGL, CA_SEGH, CA_OFFL, CA_OFFH, ROMW, ERR
  } state_t;

  localparam logic [1:0] PULSE_LAST = 2'(WR_PULSE - 1);

  state_t            state, state_nx;
  logic              dl_q;
  logic [15:0]       seg_q, off_q, len_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        din_q;
  logic [1:0]        cnt_q;
  logic [2:0]        idx_q;
  logic              rom_idle_q;
  logic              boot_q;
  logic              dl_rise, consuming, accept, strobe, strobe_last;
  logic [ADDR_W-1:0] seg_lin, off_lin;

  assign dl_rise     = ioctl_download & ~dl_q;
  assign consuming   = (state != WPULSE) && (state != ADV) && (state != ROMW);
  assign ioctl_wait  = ~consuming;
  assign accept      = ioctl_wr & consuming & ioctl_download;
  assign mem_wr      = (state == WPULSE);
  assign rom_wr      = (state == ROMW) && !rom_idle_q;
  assign strobe      = mem_wr | rom_wr;
  assign strobe_last = strobe && (cnt_q == PULSE_LAST);
  // Reset request outlives the download until any in-flight strobe has finished.
  assign load_reset  = dl_q | strobe;
  assign boot_valid  = boot_q;
  assign seg_lin     = ADDR_W'({seg_q, 4'd0});
  assign off_lin     = ADDR_W'({ioctl_dout, off_q[7:0]});

  always_comb begin
    mem_addr = base_q;
    mem_din  = din_q;
    if (state == ROMW) begin
      mem_addr = ADDR_W'(idx_q);
      case (idx_q)
        3'd0:    mem_din = 8'hEA;
        3'd1:    mem_din = off_q[7:0];
        3'd2:    mem_din = off_q[15:8];
        3'd3:    mem_din = seg_q[7:0];
        default: mem_din = seg_q[15:8];
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CMD: if (accept) begin
        if (ioctl_dout == 8'hC8)      state_nx = C8_SEGL;
        else if (ioctl_dout == 8'hCA) state_nx = CA_SEGL;
`ifdef P88_ERR_EN
        else                          state_nx = ERR;
`endif
      end
      C8_SEGL: if (accept) state_nx = C8_SEGH;
      C8_SEGH: if (accept) state_nx = C8_OFFL;
      C8_OFFL: if (accept) state_nx = C8_OFFH;
      C8_OFFH: if (accept) state_nx = SKIP0;
      SKIP0:   if (accept) state_nx = SKIP1;
      SKIP1:   if (accept) state_nx = LENL;
      LENL:    if (accept) state_nx = LENH;
      LENH:    if (accept) state_nx = ({ioctl_dout, len_q[7:0]} == 16'd0) ? CMD : DATA;
      DATA:    if (accept) state_nx = WPULSE;
      WPULSE:  if (cnt_q == PULSE_LAST) state_nx = ADV;
      ADV:     state_nx = (len_q == 16'd1) ? CMD : DATA;
      CA_SEGL: if (accept) state_nx = CA_SEGH;
      CA_SEGH: if (accept) state_nx = CA_OFFL;
      CA_OFFL: if (accept) state_nx = CA_OFFH;
      CA_OFFH: if (accept) state_nx = ROMW;
      ROMW:    if (rom_idle_q && idx_q == 3'd4) state_nx = CMD;
      ERR:     state_nx = ERR;
      default: state_nx = CMD;
    endcase
    if (dl_rise)
      state_nx = CMD;
    else if (!ioctl_download && (!strobe || strobe_last))
      state_nx = CMD;
  end

  always_ff @(posedge clk_sys or negedge resetL) begin
    if (!resetL) state <= CMD;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_sys or negedge resetL) begin
    if (!resetL) begin
      dl_q       <= 1'b0;
      seg_q      <= '0;
      off_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      rom_idle_q <= 1'b0;
      boot_q     <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      cnt_q      <= (strobe && !strobe_last) ? cnt_q + 2'd1 : 2'd0;
      rom_idle_q <= (state_nx == ROMW) && rom_wr && strobe_last;
      if (state_nx != ROMW)  idx_q <= '0;
      else if (rom_idle_q)   idx_q <= idx_q + 3'd1;
      if (dl_rise)
        boot_q <= 1'b0;
      else if (state == ROMW && rom_idle_q && idx_q == 3'd4)
        boot_q <= 1'b1;
      if (accept) begin
        case (state)
          C8_SEGL, CA_SEGL: seg_q[7:0]  <= ioctl_dout;
          C8_SEGH, CA_SEGH: seg_q[15:8] <= ioctl_dout;
          C8_OFFL, CA_OFFL: off_q[7:0]  <= ioctl_dout;
          CA_OFFH:          off_q[15:8] <= ioctl_dout;
          C8_OFFH: begin
            off_q[15:8] <= ioctl_dout;
            base_q      <= seg_lin + off_lin;
          end
          LENL:    len_q[7:0]  <= ioctl_dout;
          LENH:    len_q[15:8] <= ioctl_dout;
          DATA:    din_q       <= ioctl_dout;
          default: ;
        endcase
      end
      if (state == ADV) begin
        base_q <= base_q + ADDR_W'(1);
        len_q  <= len_q - 16'd1;
      end
    end
  end

`ifdef P88_ERR_EN
  logic err_q;
  always_ff @(posedge clk_sys or negedge resetL) begin
    if (!resetL)
      err_q <= 1'b0;
    else if (dl_rise)
      err_q <= 1'b0;
    else if (state == CMD && state_nx == ERR)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
